pc_fetch_queue: RTL and testbench

- Parametrised successor of the single-register PC stage.
- Generates fetch addresses, issues them to instruction memory over a valid/ready request channel, and accepts in-order responses with arbitrary latency.
- Buffers fetched instructions with their PCs in a FQ_DEPTH-entry queue feeding decode.
- Supports decode stall and a branch/jump redirect that flushes the queue and discards in-flight responses.

---
 rtl/pc_fetch_queue.sv | 150 +++++++++++++++
 tb/tb_pc_fetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_queue.sv
// Fetch-address generator with an in-flight address FIFO and an instruction
// queue feeding decode; redirects flush the queue and drop late responses.
module pc_fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       STEP     = 4,
  parameter int unsigned       FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pc_src,
  input  logic [ADDR_W-1:0]           pc_decode,
  input  logic                        stall,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [ADDR_W-1:0]           imem_req_addr,
  input  logic                        imem_rsp_valid,
  input  logic [INSTR_W-1:0]          imem_rsp_data,
  output logic                        out_valid,
  output logic [INSTR_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]           out_pc,
  output logic [ADDR_W-1:0]           out_pc_next,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
  localparam logic [SUM_W-1:0]  DEPTH_V = SUM_W'(FQ_DEPTH);

  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [CNT_W-1:0]   inflight_r;
  logic [CNT_W-1:0]   drop_cnt_r;
  logic [CNT_W-1:0]   q_cnt_r;
  logic [PTR_W-1:0]   af_wr_r;
  logic [PTR_W-1:0]   af_rd_r;
  logic [PTR_W-1:0]   q_wr_r;
  logic [PTR_W-1:0]   q_rd_r;
  logic [ADDR_W-1:0]  af_mem_r  [FQ_DEPTH];
  logic [ADDR_W-1:0]  q_pc_r    [FQ_DEPTH];
  logic [INSTR_W-1:0] q_instr_r [FQ_DEPTH];

  logic               credit_s;
  logic               req_fire_s;
  logic               rsp_acc_s;
  logic               push_s;
  logic               pop_s;
  logic [SUM_W-1:0]   occupancy_s;
  logic [ADDR_W-1:0]  fetch_pc_nxt_s;
  logic [CNT_W-1:0]   inflight_nxt_s;
  logic [CNT_W-1:0]   drop_nxt_s;
  logic [CNT_W-1:0]   q_cnt_nxt_s;

  // Queued plus outstanding entries never exceed the queue, so responses always fit.
  assign occupancy_s    = {1'b0, q_cnt_r} + {1'b0, inflight_r};
  assign credit_s       = (occupancy_s < DEPTH_V);
  assign imem_req_valid = reset && !pc_src && credit_s;
  assign imem_req_addr  = fetch_pc_r;

  assign out_valid   = (q_cnt_r != '0);
  assign out_instr   = q_instr_r[q_rd_r];
  assign out_pc      = q_pc_r[q_rd_r];
  assign out_pc_next = out_valid ? (out_pc + STEP_V) : '0;
  assign fq_count    = q_cnt_r;

  // Next-state computation for the fetch PC and the bookkeeping counters.
  always_comb begin
    req_fire_s     = imem_req_valid && imem_req_ready;
    rsp_acc_s      = imem_rsp_valid && (inflight_r != '0);
    push_s         = rsp_acc_s && (drop_cnt_r == '0) && !pc_src;
    pop_s          = out_valid && !stall && !pc_src;
    inflight_nxt_s = inflight_r + CNT_W'(req_fire_s) - CNT_W'(rsp_acc_s);

    if (pc_src) begin
      fetch_pc_nxt_s = pc_decode;
      q_cnt_nxt_s    = '0;
      drop_nxt_s     = inflight_r - CNT_W'(rsp_acc_s);
    end else begin
      q_cnt_nxt_s = q_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
      if (req_fire_s) begin
        fetch_pc_nxt_s = fetch_pc_r + STEP_V;
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (rsp_acc_s && (drop_cnt_r != '0)) begin
        drop_nxt_s = drop_cnt_r - CNT_W'(1'b1);
      end else begin
        drop_nxt_s = drop_cnt_r;
      end
    end
  end

  // Control state: PC, counters and FIFO/queue pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC;
      inflight_r <= '0;
      drop_cnt_r <= '0;
      q_cnt_r    <= '0;
      af_wr_r    <= '0;
      af_rd_r    <= '0;
      q_wr_r     <= '0;
      q_rd_r     <= '0;
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      inflight_r <= inflight_nxt_s;
      drop_cnt_r <= drop_nxt_s;
      q_cnt_r    <= q_cnt_nxt_s;
      if (req_fire_s) begin
        af_wr_r <= af_wr_r + PTR_W'(1'b1);
      end
      if (rsp_acc_s) begin
        af_rd_r <= af_rd_r + PTR_W'(1'b1);
      end
      if (pc_src) begin
        q_wr_r <= '0;
        q_rd_r <= '0;
      end else begin
        if (push_s) begin
          q_wr_r <= q_wr_r + PTR_W'(1'b1);
        end
        if (pop_s) begin
          q_rd_r <= q_rd_r + PTR_W'(1'b1);
        end
      end
    end
  end

  // Storage: issued addresses awaiting responses, and the decoded-facing queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        af_mem_r[i]  <= '0;
        q_pc_r[i]    <= '0;
        q_instr_r[i] <= '0;
      end
    end else begin
      if (req_fire_s) begin
        af_mem_r[af_wr_r] <= fetch_pc_r;
      end
      if (push_s) begin
        q_instr_r[q_wr_r] <= imem_rsp_data;
        q_pc_r[q_wr_r]    <= af_mem_r[af_rd_r];
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Bench for pc_fetch_queue: latency-configurable memory model plus a
// queue-based reference of issued requests and queued PCs.
module tb_pc_fetch_queue;

  logic        clk;
  logic        reset;
  logic        pc_src;
  logic [31:0] pc_decode;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [2:0]  fq_count;

  pc_fetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0100), .STEP(4), .FQ_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .pc_decode(pc_decode), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_pc_next(out_pc_next),
    .fq_count(fq_count)
  );

  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  req_t        outq[$];
  logic [31:0] fq[$];
  mreq_t       memq[$];
  logic [31:0] next_pc;
  int          cyc;
  int          lat;
  int          last_due;
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    outq.delete();
    fq.delete();
    memq.delete();
    next_pc  = 32'h0000_0100;
    last_due = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0000_0100);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_instr"}, out_instr, 32'h0);
    chk({tag, "_out_pc"}, out_pc, 32'h0);
    chk({tag, "_out_pc_next"}, out_pc_next, 32'h0);
    chk({tag, "_fq_count"}, fq_count, 32'h0);
  endtask

  // One clock cycle: drive at negedge, check, then advance memory and model at posedge.
  task automatic step(input bit src, input logic [31:0] tgt, input bit st, input bit rdy);
    bit          rv;
    bit          exp_rv;
    bit          dut_rv;
    logic [31:0] rd;
    logic [31:0] dut_addr;
    int          due;
    req_t        r;
    rv = 1'b0;
    rd = 32'h0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rv = 1'b1;
      rd = instr_of(memq[0].addr);
    end else if (memq.size() == 0 && $urandom_range(0, 7) == 0) begin
      rv = 1'b1;
      rd = 32'hBAD0_BAD0;
    end
    pc_src = src; pc_decode = tgt; stall = st; imem_req_ready = rdy;
    imem_rsp_valid = rv; imem_rsp_data = rd;
    #1;
    exp_rv = !src && ((fq.size() + outq.size()) < 4);
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, next_pc);
    chk("out_valid", out_valid, fq.size() > 0);
    chk("fq_count", fq_count, fq.size());
    chk("fq_bound", fq_count <= 3'd4, 1'b1);
    if (fq.size() > 0) begin
      chk("out_pc", out_pc, fq[0]);
      chk("out_instr", out_instr, instr_of(fq[0]));
      chk("out_pc_next", out_pc_next, fq[0] + 32'd4);
    end
    dut_rv   = imem_req_valid;
    dut_addr = imem_req_addr;
    @(posedge clk);
    if (rv && memq.size() > 0) void'(memq.pop_front());
    if (dut_rv && rdy) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{dut_addr, due});
    end
    chk("inflight_bound", memq.size() <= 4, 1'b1);
    if (src) begin
      if (rv && outq.size() > 0) void'(outq.pop_front());
      foreach (outq[i]) outq[i].stale = 1'b1;
      fq.delete();
      next_pc = tgt;
    end else begin
      if (fq.size() > 0 && !st) void'(fq.pop_front());
      if (rv && outq.size() > 0) begin
        r = outq.pop_front();
        if (!r.stale) fq.push_back(r.addr);
      end
      if (exp_rv && rdy) begin
        outq.push_back('{next_pc, 1'b0});
        next_pc = next_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; lat = 1; last_due = 0;
    reset = 1'b0; pc_src = 1'b0; pc_decode = 32'h0; stall = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Sequential fetch from RESET_PC with 1-cycle memory.
    lat = 1;
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("first_out_valid", out_valid, 1'b1);
    chk("first_out_pc", out_pc, 32'h0000_0100);
    chk("first_out_pc_next", out_pc_next, 32'h0000_0104);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Stall fills the queue and starves the request channel.
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("stall_full_count", fq_count, 3'd4);
    chk("stall_req_valid", imem_req_valid, 1'b0);
    chk("stall_inflight", memq.size(), 0);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b0);

    // 3-cycle memory with toggling ready and occasional stall.
    lat = 3;
    for (int i = 0; i < 60; i++)
      step(1'b0, 32'h0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));

    // Redirect with three requests outstanding.
    for (int i = 0; i < 20; i++) begin
      if (memq.size() == 3) break;
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end
    chk("pre_redirect_inflight", memq.size(), 3);
    step(1'b1, 32'h0000_2000, 1'b0, 1'b1);
    chk("redirect_out_valid", out_valid, 1'b0);
    chk("redirect_fq_count", fq_count, 3'd0);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end
    chk("redirect_first_pc", out_pc, 32'h0000_2000);

    // Redirect coinciding with a response and a pop.
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      if (fq.size() > 0 && memq.size() > 0 && memq[0].due <= cyc) break;
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end
    step(1'b1, 32'h0000_3000, 1'b0, 1'b1);
    chk("redirect2_fq_count", fq_count, 3'd0);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end
    chk("redirect2_first_pc", out_pc, 32'h0000_3000);

    // Redirect near the top of the address space exercises wrap-around.
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Random mix including back-to-back redirects and varying latency.
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      step($urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset mid-burst with the queue partly filled.
    lat = 2;
    for (int i = 0; i < 20; i++) begin
      if (fq.size() == 2) break;
      step(1'b0, 32'h0, 1'b1, 1'b1);
    end
    chk("pre_reset_fq_count", fq_count, 3'd2);
    pc_src = 1'b0; stall = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    cyc++;
    model_reset();
    reset = 1'b1;
    lat = 1;
    repeat (15) step(1'b0, 32'h0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
